// File: rtl/brick_pkg.sv
// Shared types and helpers for the brick field sequencer and its health store.
// Optional draw watchdog is enabled by BRICK_SEQ_DRAW_TIMEOUT_EN.
package brick_pkg;

    localparam int COORD_W = 10;
    localparam int ROW_W   = 3;
    localparam int COL_W   = 4;
    localparam int LEFT_W  = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_GO   = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    typedef logic [1:0]         health_t;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_SCAN = S_SCAN,
        ST_GO   = S_GO,
        ST_WAIT = S_WAIT
    } state_t;

    // Pixel position of the n-th brick along one axis, truncated to the coordinate width.
    function automatic coord_t coord_of(input int base, input int n, input int pitch);
        return coord_t'(base + n * pitch);
    endfunction

endpackage

// File: rtl/brick_field_mem.sv
// Per-brick health and dirty bits, hit acceptance and the live-brick counter.
// Init has priority over hits and over the sequencer's dirty updates.
module brick_field_mem
    import brick_pkg::*;
#(
    parameter int  ROWS        = 4,
    parameter int  COLS        = 8,
    parameter int  INIT_HEALTH = 3,
    localparam int NB          = ROWS * COLS,
    localparam int IDX_W       = $clog2(NB)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              init,
    input  logic              hit_valid,
    input  logic [ROW_W-1:0]  hit_row,
    input  logic [COL_W-1:0]  hit_col,
    output logic              hit_accepted,
    input  logic [IDX_W-1:0]  rd_idx,
    output health_t           rd_health,
    output logic              rd_dirty,
    input  logic              clr_en,
    input  logic              set_en,
    output logic              dirty_any,
    output logic [LEFT_W-1:0] bricks_left
);

    health_t          health [NB];
    logic [NB-1:0]    dirty;
    logic [IDX_W-1:0] hit_idx;
    logic             in_range;
    health_t          health_hit;
    logic             accept;

    always_comb begin
        in_range   = (int'(hit_row) < ROWS) && (int'(hit_col) < COLS);
        hit_idx    = IDX_W'(int'(hit_row) * COLS + int'(hit_col));
        health_hit = in_range ? health[hit_idx] : '0;
        accept     = hit_valid && !init && in_range && (health_hit != '0);
    end

    assign rd_health = health[rd_idx];
    assign rd_dirty  = dirty[rd_idx];
    assign dirty_any = |dirty;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NB; i++) health[i] <= '0;
            dirty        <= '0;
            bricks_left  <= '0;
            hit_accepted <= 1'b0;
        end else if (init) begin
            for (int i = 0; i < NB; i++) health[i] <= health_t'(INIT_HEALTH);
            dirty        <= '1;
            bricks_left  <= LEFT_W'(NB);
            hit_accepted <= 1'b0;
        end else begin
            hit_accepted <= accept;
            if (clr_en) dirty[rd_idx] <= 1'b0;
            if (set_en) dirty[rd_idx] <= 1'b1;
            // A hit's dirty set lands last so a same-cycle scan clear cannot lose the redraw.
            if (accept) begin
                health[hit_idx] <= health_hit - 2'd1;
                dirty[hit_idx]  <= 1'b1;
                if (health_hit == 2'd1) bricks_left <= bricks_left - 6'd1;
            end
        end
    end

endmodule

// File: rtl/brick_field_sequencer.sv
// Scans dirty bricks and hands them one at a time to the rectangle drawer.
// Define BRICK_SEQ_DRAW_TIMEOUT_EN to add the draw watchdog and sticky draw_error.
//
// state | meaning
// IDLE  | nothing dirty, waiting for hits or init
// SCAN  | test one brick per cycle at scan_idx
// GO    | draw_go high for one cycle
// WAIT  | hold brick outputs until draw_done
module brick_field_sequencer
    import brick_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 8,
    parameter int BRICK_W     = 40,
    parameter int BRICK_H     = 16,
    parameter int GAP         = 0,
    parameter int X0          = 0,
    parameter int Y0          = 32,
    parameter int INIT_HEALTH = 3,
    parameter int TIMEOUT     = 1023
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              init,
    input  logic              hit_valid,
    input  logic [ROW_W-1:0]  hit_row,
    input  logic [COL_W-1:0]  hit_col,
    output logic              hit_accepted,
    input  logic              draw_done,
    output logic              draw_go,
    output health_t           brick_health,
    output coord_t            brick_x,
    output coord_t            brick_y,
    output coord_t            brick_width,
    output coord_t            brick_height,
    output logic [LEFT_W-1:0] bricks_left,
    output logic              field_clear,
    output logic              busy,
    output logic              draw_error
);

    localparam int NB    = ROWS * COLS;
    localparam int IDX_W = $clog2(NB);

    state_t           state;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] next_idx;
    health_t          rd_health;
    logic             rd_dirty;
    logic             dirty_any;
    logic             clr_en;
    logic             set_en;

    brick_field_mem #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .INIT_HEALTH (INIT_HEALTH)
    ) u_mem (
        .clk          (clk),
        .resetn       (resetn),
        .init         (init),
        .hit_valid    (hit_valid),
        .hit_row      (hit_row),
        .hit_col      (hit_col),
        .hit_accepted (hit_accepted),
        .rd_idx       (scan_idx),
        .rd_health    (rd_health),
        .rd_dirty     (rd_dirty),
        .clr_en       (clr_en),
        .set_en       (set_en),
        .dirty_any    (dirty_any),
        .bricks_left  (bricks_left)
    );

    assign next_idx     = (scan_idx == IDX_W'(NB - 1)) ? '0 : scan_idx + 1'b1;
    assign clr_en       = (state == ST_SCAN) && rd_dirty;
    assign busy         = (state != ST_IDLE) || dirty_any;
    assign field_clear  = (bricks_left == '0);
    assign brick_width  = coord_t'(BRICK_W);
    assign brick_height = coord_t'(BRICK_H);

`ifdef BRICK_SEQ_DRAW_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            timeout;

    assign timeout = (state == ST_WAIT) && !draw_done && (wd_cnt == '0);
    assign set_en  = timeout;
`else
    assign set_en     = 1'b0;
    assign draw_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            scan_idx     <= '0;
            draw_go      <= 1'b0;
            brick_health <= '0;
            brick_x      <= '0;
            brick_y      <= '0;
`ifdef BRICK_SEQ_DRAW_TIMEOUT_EN
            wd_cnt       <= '0;
            draw_error   <= 1'b0;
`endif
        end else if (init) begin
            state    <= ST_SCAN;
            scan_idx <= '0;
            draw_go  <= 1'b0;
        end else begin
            draw_go <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dirty_any) state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (rd_dirty) begin
                        brick_health <= rd_health;
                        brick_x      <= coord_of(X0, int'(scan_idx) % COLS, BRICK_W + GAP);
                        brick_y      <= coord_of(Y0, int'(scan_idx) / COLS, BRICK_H + GAP);
                        draw_go      <= 1'b1;
                        state        <= ST_GO;
                    end else if (!dirty_any) begin
                        state <= ST_IDLE;
                    end else begin
                        scan_idx <= next_idx;
                    end
                end
                ST_GO: begin
                    state <= ST_WAIT;
`ifdef BRICK_SEQ_DRAW_TIMEOUT_EN
                    wd_cnt <= WD_W'(TIMEOUT - 1);
`endif
                end
                ST_WAIT: begin
                    if (draw_done) begin
                        scan_idx <= next_idx;
                        state    <= ST_SCAN;
                    end
`ifdef BRICK_SEQ_DRAW_TIMEOUT_EN
                    // Watchdog expiry retries the same brick; its dirty bit is re-set in the store.
                    else if (timeout) begin
                        draw_error <= 1'b1;
                        state      <= ST_SCAN;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
